// File: rtl/joybus_pkg.sv
// rtl/joybus_pkg.sv - shared timing constants, counter sizing and state enum for the joybus transmitter
package joybus_pkg;

   localparam int DEF_US_CYC      = 50;
   localparam int DEF_STOP_LOW_US = 2;
   localparam int DEF_GAP_US      = 4;

   localparam int CELL_US  = 4;
   localparam int SHORT_US = 1;
   localparam int LONG_US  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_STOP_LOW,
      ST_GAP
   } tx_state_t;

   // Counter holds (length - 1), so the longest phase needs clog2(longest) bits.
   function automatic int cnt_w(input int us, input int stop_us, input int gap_us);
      int m;
      m = CELL_US * us;
      if (stop_us * us > m) m = stop_us * us;
      if (gap_us * us > m)  m = gap_us * us;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/joybus_cell_timer.sv
// rtl/joybus_cell_timer.sv - loadable down-counter; tc is high while the count sits at zero
module joybus_cell_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/joybus_tx.sv
// rtl/joybus_tx.sv - joybus single-wire transmitter: hold register, MSB-first shifter, cell/stop FSM
// Optional post-stop idle gap enabled by defining JOYBUS_TX_GAP_EN.
module joybus_tx
   import joybus_pkg::*;
#(
   parameter int US_CYC      = DEF_US_CYC,
   parameter int STOP_LOW_US = DEF_STOP_LOW_US,
   parameter int GAP_US      = DEF_GAP_US
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       jb_drive_low,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam int W = cnt_w(US_CYC, STOP_LOW_US, GAP_US);
   localparam logic [W-1:0] SHORT_M1 = W'(SHORT_US * US_CYC - 1);
   localparam logic [W-1:0] LONG_M1  = W'(LONG_US * US_CYC - 1);
   localparam logic [W-1:0] STOP_M1  = W'(STOP_LOW_US * US_CYC - 1);
`ifdef JOYBUS_TX_GAP_EN
   localparam logic [W-1:0] GAP_M1   = W'(GAP_US * US_CYC - 1);
`endif

   tx_state_t    state;
   logic [7:0]   hold_data;
   logic         hold_valid;
   logic         hold_last;
   logic [7:0]   shreg;
   logic [2:0]   bit_cnt;
   logic         cur_last;
   logic         live;
   logic         tmr_load;
   logic         tmr_tc;
   logic [W-1:0] tmr_val;

   function automatic logic [W-1:0] low_m1(input logic b);
      return b ? SHORT_M1 : LONG_M1;
   endfunction

   function automatic logic [W-1:0] high_m1(input logic b);
      return b ? LONG_M1 : SHORT_M1;
   endfunction

   assign s_ready = live & ~hold_valid;

   // Timer reload mirrors the FSM transitions below so the next phase starts on the same edge.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: begin
            tmr_load = hold_valid;
            tmr_val  = low_m1(hold_data[7]);
         end
         ST_BIT_LOW: begin
            tmr_load = tmr_tc;
            tmr_val  = high_m1(shreg[7]);
         end
         ST_BIT_HIGH: begin
            tmr_load = tmr_tc;
            if (bit_cnt != 3'd0)
               tmr_val = low_m1(shreg[6]);
            else if (!cur_last && hold_valid)
               tmr_val = low_m1(hold_data[7]);
            else
               tmr_val = STOP_M1;
         end
         ST_STOP_LOW: begin
`ifdef JOYBUS_TX_GAP_EN
            tmr_load = tmr_tc;
            tmr_val  = GAP_M1;
`endif
         end
         default: ;
      endcase
   end

   joybus_cell_timer #(.W(W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         hold_data    <= '0;
         hold_valid   <= 1'b0;
         hold_last    <= 1'b0;
         shreg        <= '0;
         bit_cnt      <= '0;
         cur_last     <= 1'b0;
         live         <= 1'b0;
         jb_drive_low <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         live     <= 1'b1;
         done     <= 1'b0;
         underrun <= 1'b0;
         if (s_valid && s_ready) begin
            hold_data  <= s_data;
            hold_last  <= s_last;
            hold_valid <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (hold_valid) begin
                  shreg        <= hold_data;
                  cur_last     <= hold_last;
                  hold_valid   <= 1'b0;
                  bit_cnt      <= 3'd7;
                  jb_drive_low <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ST_BIT_LOW;
               end
            end
            ST_BIT_LOW: begin
               if (tmr_tc) begin
                  jb_drive_low <= 1'b0;
                  state        <= ST_BIT_HIGH;
               end
            end
            ST_BIT_HIGH: begin
               if (tmr_tc) begin
                  jb_drive_low <= 1'b1;
                  if (bit_cnt != 3'd0) begin
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt - 3'd1;
                     state   <= ST_BIT_LOW;
                  end else if (cur_last) begin
                     state <= ST_STOP_LOW;
                  end else if (hold_valid) begin
                     shreg      <= hold_data;
                     cur_last   <= hold_last;
                     hold_valid <= 1'b0;
                     bit_cnt    <= 3'd7;
                     state      <= ST_BIT_LOW;
                  end else begin
                     underrun <= 1'b1;
                     state    <= ST_STOP_LOW;
                  end
               end
            end
            ST_STOP_LOW: begin
               if (tmr_tc) begin
                  jb_drive_low <= 1'b0;
                  done         <= 1'b1;
`ifdef JOYBUS_TX_GAP_EN
                  state        <= ST_GAP;
`else
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
`endif
               end
            end
            ST_GAP: begin
               if (tmr_tc) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               jb_drive_low <= 1'b0;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_joybus_tx.sv
// tb/tb_joybus_tx.sv - scoreboard bench: stimulus queues expected frames, a monitor decodes the line
module tb_joybus_tx;

   localparam int CELL = 200;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic       jb_drive_low;
   logic       busy;
   logic       done;
   logic       underrun;

   typedef struct {
      int          n;
      logic [31:0] data;
      int          ur;
      int          dur;
      int          gap_min;
      int          gap_max;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   joybus_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .jb_drive_low (jb_drive_low),
      .busy         (busy),
      .done         (done),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      total_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic exp_t mk(input int n, input logic [31:0] d, input int ur, input int dur,
                               input int gmin, input int gmax);
      exp_t e;
      e.n = n; e.data = d; e.ur = ur; e.dur = dur; e.gap_min = gmin; e.gap_max = gmax;
      return e;
   endfunction

   // Monitor: measures low-phase widths at negedge and checks frames against the scoreboard head.
   int          cyc = 0;
   logic        prev_line = 1'b0;
   bit          in_frame = 0;
   bit          have_rel = 0;
   bit          stop_now;
   int          frame_start, seg_start, nbits, ur_cnt, cell_err, last_rel, w, g;
   logic        ur_at_seg;
   logic [31:0] acc;
   exp_t        cur;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         stop_now = 0;
         if (!rst_n) begin
            prev_line = 1'b0;
            in_frame  = 0;
            have_rel  = 0;
         end else begin
            if (jb_drive_low && !prev_line) begin
               if (!in_frame) begin
                  in_frame = 1; frame_start = cyc; nbits = 0; acc = '0; ur_cnt = 0; cell_err = 0;
                  if (sb.size() == 0) begin
                     check("unexpected_frame", 1, 0);
                     cur = mk(0, 0, 0, 0, -1, -1);
                  end else begin
                     cur = sb[0];
                     if (cur.gap_min >= 0) begin
                        g = have_rel ? cyc - last_rel : -1;
                        check($sformatf("gap_in_range_%0d", g), int'(g >= cur.gap_min && g <= cur.gap_max), 1);
                     end
                  end
               end else if (cyc - seg_start != CELL) begin
                  cell_err++;
               end
               seg_start = cyc;
               ur_at_seg = underrun;
            end
            if (underrun && in_frame) ur_cnt++;
            if (!jb_drive_low && prev_line && in_frame) begin
               w = cyc - seg_start;
               if (w == 50) begin
                  acc = {acc[30:0], 1'b1}; nbits++;
               end else if (w == 150) begin
                  acc = {acc[30:0], 1'b0}; nbits++;
               end else if (w == 100) begin
                  stop_now = 1;
                  check("nbits", nbits, 8 * cur.n);
                  check("data", int'(acc), int'(cur.data));
                  check("duration", cyc - frame_start, cur.dur);
                  check("done_at_stop", int'(done), 1);
                  check("underrun_at_stop", int'(ur_at_seg), cur.ur);
                  check("underrun_count", ur_cnt, cur.ur);
                  check("cell_len_errors", cell_err, 0);
                  if (sb.size() > 0) cur = sb.pop_front();
                  in_frame = 0;
                  have_rel = 1;
                  last_rel = cyc;
               end else begin
                  check("low_width", w, 50);
               end
            end
            if (done && !stop_now) check("stray_done", 1, 0);
            prev_line = jb_drive_low;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l, output int n);
      s_data = d; s_last = l; s_valid = 1'b1; n = 0;
      while (!s_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("send_timeout", 0, 1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_frames();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 8000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8000) check("frame_timeout", 0, 1);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete");
      total_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      exp_t tmp;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_drive_low", int'(jb_drive_low), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_s_ready", int'(s_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", int'(s_ready), 1);

      // single byte 0x80: 50/150 then 7x 150/50, stop, done 1700 after first low
      sb.push_back(mk(1, 32'h80, 0, 1700, -1, -1));
      send(8'h80, 1'b1, n);
      check("hold_full_s_ready", int'(s_ready), 0);
      @(negedge clk);
      check("shifter_loaded_s_ready", int'(s_ready), 1);
      wait_frames();

      // three bytes back-to-back, third byte stalls until first byte boundary
      sb.push_back(mk(3, 32'h0000FF5A, 0, 24 * CELL + 100, -1, -1));
      send(8'h00, 1'b0, n);
      check("b1_hold_s_ready", int'(s_ready), 0);
      send(8'hFF, 1'b0, n);
      check("b2_wait", n, 1);
      check("b2_hold_s_ready", int'(s_ready), 0);
      send(8'h5A, 1'b1, n);
      check($sformatf("b3_stall_%0d", n), int'(n > 1000 && n < 1700), 1);
      wait_frames();

      // underrun: 0x12 without last and nothing behind it
      sb.push_back(mk(1, 32'h12, 1, 1700, -1, -1));
      send(8'h12, 1'b0, n);
      wait_frames();

      // reset in the middle of byte 2 while the line is driven low
      sb.push_back(mk(2, 32'h3344, 0, 16 * CELL + 100, -1, -1));
      send(8'h33, 1'b0, n);
      send(8'h44, 1'b1, n);
      repeat (1700) @(negedge clk);
      n = 0;
      while (!jb_drive_low && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_low", int'(jb_drive_low), 1);
      #3 rst_n = 1'b0;
      #1;
      check("async_release", int'(jb_drive_low), 0);
      check("async_busy", int'(busy), 0);
      tmp = sb.pop_front();
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_done", int'(done), 0);
         check("rst_mid_underrun", int'(underrun), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      sb.push_back(mk(1, 32'h01, 0, 1700, -1, -1));
      send(8'h01, 1'b1, n);
      wait_frames();

      // two single-byte frames queued: inter-frame gap
`ifdef JOYBUS_TX_GAP_EN
      sb.push_back(mk(1, 32'hA1, 0, 1700, -1, -1));
      sb.push_back(mk(1, 32'h5E, 0, 1700, 200, 210));
`else
      sb.push_back(mk(1, 32'hA1, 0, 1700, -1, -1));
      sb.push_back(mk(1, 32'h5E, 0, 1700, 1, 1));
`endif
      send(8'hA1, 1'b1, n);
      send(8'h5E, 1'b1, n);
      wait_frames();

      check("scoreboard_empty", sb.size(), 0);
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
